// File: rtl/register_sequencer_pkg.sv
// Shared constants for the register sequencer: opcodes, shift directions, FSM state codes.
package register_sequencer_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_EXEC = 3'b011;
    localparam logic [2:0] OP_LSH  = 3'b100;
    localparam logic [2:0] OP_RSH  = 3'b101;
    localparam logic [2:0] OP_SHLD = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] SH_LSH  = 2'b10;
    localparam logic [1:0] SH_RSH  = 2'b01;
    localparam logic [1:0] SH_HOLD = 2'b00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_LSH) || (op == OP_RSH);
    endfunction

endpackage

// File: rtl/register_sequencer_counter.sv
// Loadable down-counter timing the WAIT and SHIFT states; saturates at zero.
module seq_down_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    // Terminal count is the last cycle of the timed state, not zero.
    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/register_sequencer.sv
// Moore control sequencer driving register-file and shift-register enables from a 3-bit opcode.
module register_sequencer
    import register_sequencer_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [2:0]       instr_op,
    input  logic [CNT_W-1:0] instr_cnt,
    output logic             instr_ready,
    output logic             lda,
    output logic             ldb,
    output logic             ldo,
    output logic             shift_load,
    output logic [1:0]       shift_state,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [2:0]       state, next_state;
    logic [2:0]       op_q;
    logic             cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0] cnt_val;
    logic             accept;

    assign accept = (state == ST_IDLE) && instr_valid;

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = instr_cnt;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (instr_op == OP_NOP || instr_op == OP_ILL)
                        next_state = ST_DONE;
                    else if (is_shift(instr_op)) begin
                        if (instr_cnt == '0)
                            next_state = ST_DONE;
                        else begin
                            next_state = ST_SHIFT;
                            cnt_load   = 1'b1;
                        end
                    end else
                        next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (op_q == OP_EXEC) begin
                    next_state = ST_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(ALU_LAT);
                end else
                    next_state = ST_DONE;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_tc) next_state = ST_STORE;
            end
            ST_STORE: next_state = ST_DONE;
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_tc) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
        end else begin
            state <= next_state;
            if (accept) op_q <= instr_op;
        end
    end

    seq_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    // Outputs decode registered state and the opcode latched at accept only.
    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = (state == ST_DONE) && (op_q == OP_ILL);
    assign lda         = (state == ST_LOAD) && (op_q == OP_LDA || op_q == OP_EXEC);
    assign ldb         = (state == ST_LOAD) && (op_q == OP_LDB || op_q == OP_EXEC);
    assign shift_load  = (state == ST_LOAD) && (op_q == OP_SHLD);
    assign ldo         = (state == ST_STORE);
    assign shift_state = (state != ST_SHIFT) ? SH_HOLD :
                         (op_q == OP_LSH)    ? SH_LSH  : SH_RSH;

endmodule

// File: tb/tb_register_sequencer.sv
// Directed checks of the register sequencer timing plus a random exclusivity sweep.
module tb_register_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic [2:0] instr_op = 3'b000;
    logic [2:0] instr_cnt = 3'd0;
    logic       instr_ready, lda, ldb, ldo, shift_load, busy, done, err;
    logic [1:0] shift_state;
    logic [9:0] obs;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    // Observation order: ready busy done err lda ldb ldo shift_load shift_state[1:0]
    localparam logic [9:0] V_IDLE  = 10'b1000_0000_00;
    localparam logic [9:0] V_LEXEC = 10'b0100_1100_00;
    localparam logic [9:0] V_LDA   = 10'b0100_1000_00;
    localparam logic [9:0] V_LDB   = 10'b0100_0100_00;
    localparam logic [9:0] V_SHLD  = 10'b0100_0001_00;
    localparam logic [9:0] V_WAIT  = 10'b0100_0000_00;
    localparam logic [9:0] V_STORE = 10'b0100_0010_00;
    localparam logic [9:0] V_SHL   = 10'b0100_0000_10;
    localparam logic [9:0] V_SHR   = 10'b0100_0000_01;
    localparam logic [9:0] V_DONE  = 10'b0110_0000_00;
    localparam logic [9:0] V_DERR  = 10'b0111_0000_00;

    always #5 clk = ~clk;

    assign obs = {instr_ready, busy, done, err, lda, ldb, ldo, shift_load, shift_state};

    register_sequencer #(.ALU_LAT(1), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_cnt   (instr_cnt),
        .instr_ready (instr_ready),
        .lda         (lda),
        .ldb         (ldb),
        .ldo         (ldo),
        .shift_load  (shift_load),
        .shift_state (shift_state),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_valid = 1'b1;
        instr_op = 3'b001;
        for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt++;
            if (obs !== V_IDLE) $display("FAIL reset_hold c%0d: got %b want %b", k, obs, V_IDLE);
            else pass_cnt++;
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (obs !== V_IDLE) $display("FAIL reset_release: got %b want %b", obs, V_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_exec();
        logic [9:0] exp [5];
        exp = '{V_LEXEC, V_WAIT, V_STORE, V_DONE, V_IDLE};
        instr_valid = 1'b1; instr_op = 3'b011; instr_cnt = 3'd0;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            total_cnt++;
            if (obs !== exp[k-1]) $display("FAIL exec c%0d: got %b want %b", k, obs, exp[k-1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_loads();
        logic [2:0] ops [4];
        logic [9:0] first [4];
        ops   = '{3'b001, 3'b010, 3'b110, 3'b000};
        first = '{V_LDA, V_LDB, V_SHLD, V_DONE};
        for (int i = 0; i < 4; i++) begin
            instr_valid = 1'b1; instr_op = ops[i]; instr_cnt = 3'd5;
            tick();
            instr_valid = 1'b0;
            total_cnt++;
            if (obs !== first[i]) $display("FAIL load op%0d c1: got %b want %b", ops[i], obs, first[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (obs !== (i == 3 ? V_IDLE : V_DONE))
                $display("FAIL load op%0d c2: got %b want %b", ops[i], obs, (i == 3 ? V_IDLE : V_DONE));
            else pass_cnt++;
            if (i != 3) tick();
        end
    endtask

    task automatic test_shift();
        logic [9:0] exp [5];
        exp = '{V_SHL, V_SHL, V_SHL, V_DONE, V_IDLE};
        instr_valid = 1'b1; instr_op = 3'b100; instr_cnt = 3'd3;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            total_cnt++;
            if (obs !== exp[k-1]) $display("FAIL lsh3 c%0d: got %b want %b", k, obs, exp[k-1]);
            else pass_cnt++;
        end
        instr_valid = 1'b1; instr_op = 3'b101; instr_cnt = 3'd0;
        tick();
        instr_valid = 1'b0;
        total_cnt++;
        if (obs !== V_DONE) $display("FAIL rsh0 c1: got %b want %b", obs, V_DONE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== V_IDLE) $display("FAIL rsh0 c2: got %b want %b", obs, V_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_max_shift();
        instr_valid = 1'b1; instr_op = 3'b101; instr_cnt = 3'd7;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [9:0] e;
            if (k > 1) tick();
            e = (k <= 7) ? V_SHR : (k == 8) ? V_DONE : V_IDLE;
            total_cnt++;
            if (obs !== e) $display("FAIL rsh7 c%0d: got %b want %b", k, obs, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1; instr_op = 3'b111; instr_cnt = 3'd2;
        tick();
        instr_valid = 1'b0;
        total_cnt++;
        if (obs !== V_DERR) $display("FAIL illegal c1: got %b want %b", obs, V_DERR);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== V_IDLE) $display("FAIL illegal c2: got %b want %b", obs, V_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [6];
        exp = '{V_SHLD, V_DONE, V_IDLE, V_LDA, V_DONE, V_IDLE};
        instr_valid = 1'b1; instr_op = 3'b110; instr_cnt = 3'd0;
        tick();
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            total_cnt++;
            if (obs !== exp[k-1]) $display("FAIL b2b c%0d: got %b want %b", k, obs, exp[k-1]);
            else pass_cnt++;
            if (k == 1) instr_op = 3'b001;
            if (k == 4) instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        instr_valid = 1'b1; instr_op = 3'b100; instr_cnt = 3'd7;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            total_cnt++;
            if (obs !== V_SHL) $display("FAIL rstmid c%0d: got %b want %b", k, obs, V_SHL);
            else pass_cnt++;
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            if (k > 5) tick();
            total_cnt++;
            if (obs !== V_IDLE) $display("FAIL rstmid c%0d: got %b want %b", k, obs, V_IDLE);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            int n;
            if (instr_ready) begin
                instr_valid = ($urandom_range(0, 3) != 0);
                instr_op    = 3'($urandom_range(0, 7));
                instr_cnt   = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 1) == 0) begin
                instr_op  = 3'($urandom_range(0, 7));
                instr_cnt = 3'($urandom_range(0, 7));
            end
            tick();
            n = int'(lda | ldb) + int'(ldo) + int'(shift_load) + int'(shift_state != 2'b00);
            total_cnt++;
            if (n > 1 || shift_state === 2'b11)
                $display("FAIL rand_excl c%0d: got n=%0d ss=%b want n<=1 ss!=11", c, n, shift_state);
            else pass_cnt++;
            total_cnt++;
            if ((err && !done) || (instr_ready === busy))
                $display("FAIL rand_flags c%0d: got err=%b done=%b ready=%b busy=%b", c, err, done, instr_ready, busy);
            else pass_cnt++;
        end
        instr_valid = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        test_reset();
        test_exec();
        test_loads();
        test_shift();
        test_max_shift();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1: ALU settle cycles (1..7) between operand load and result store.
REQ-002 Parameter CNT_W, default 3: width of the shift count field.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (reset=0 at posedge clk resets the block).
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_op  input  3  opcode: 000 NOP, 001 LDA, 010 LDB, 011 EXEC, 100 LSH, 101 RSH, 110 SHLD, 111 illegal.
REQ-007 instr_cnt  input  CNT_W  shift count for LSH/RSH; ignored otherwise.
REQ-008 instr_ready  output  1  block can accept an instruction.
REQ-009 lda / ldb / ldo  output  1 each  A/B/O register load enables.
REQ-010 shift_load  output  1  shift-register parallel load enable.
REQ-011 shift_state  output  2  10 = LSH, 01 = RSH, 00 = hold; 11 is never driven.
REQ-012 busy  output  1  instruction in progress (state != IDLE).
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.

Function
REQ-015 States: IDLE, LOAD, WAIT, STORE, SHIFT, DONE; all outputs are registered or decoded from state only (Moore), with no combinational path from inputs to outputs.
REQ-016 instr_ready = 1 only in IDLE; an instruction is accepted on a posedge where instr_valid=1 and instr_ready=1; instr_op and instr_cnt are captured at that edge.
REQ-017 An instr_valid arriving while busy is not accepted, and the offered instruction is neither dropped nor queued by the block.
REQ-018 NOP: IDLE -> DONE.
REQ-019 LDA: IDLE -> LOAD (lda=1 for 1 cycle) -> DONE.
REQ-020 LDB: IDLE -> LOAD (ldb=1 for 1 cycle) -> DONE.
REQ-021 SHLD: IDLE -> LOAD (shift_load=1 for 1 cycle) -> DONE.
REQ-022 EXEC: IDLE -> LOAD (lda=ldb=1 for 1 cycle) -> WAIT (exactly ALU_LAT cycles) -> STORE (ldo=1 for 1 cycle) -> DONE.
REQ-023 LSH/RSH with cnt>0: IDLE -> SHIFT for exactly cnt cycles (shift_state=10 or 01) -> DONE.
REQ-024 LSH/RSH with cnt=0: IDLE -> DONE, with no shift cycle.
REQ-025 Illegal opcode 111: IDLE -> DONE with err=1; no load or shift output is asserted.
REQ-026 DONE lasts 1 cycle (done=1, instr_ready=0) and then returns to IDLE.
REQ-027 Accept-to-done latency: NOP and cnt=0 shifts = 1 cycle; LDA/LDB/SHLD = 2; EXEC = ALU_LAT+3; shifts = cnt+1.
REQ-028 Minimum issue interval is done cycle + 1; back-to-back instructions are never accepted in DONE.
REQ-029 At most one of lda/ldb (excluding EXEC LOAD), ldo, shift_load, or nonzero shift_state is active in any cycle; shift_load and shift_state are never active together.
REQ-030 A CNT_W-bit down-counter loads cnt (shift) or ALU_LAT (wait) on state entry and leaves the state when it reaches 1; the counter does not wrap.
REQ-031 Maximum cnt (2^CNT_W-1 = 7) yields exactly 7 shift cycles.

Reset
REQ-032 reset=0 at a posedge forces: state=IDLE, counter=0, instr_ready=1, busy=0, done=0, err=0, lda=ldb=ldo=shift_load=0, shift_state=00.
REQ-033 reset asserted mid-instruction aborts it with no done pulse, and all enables are low from the next cycle.
REQ-034 An instruction offered while reset=0 is not accepted.

Structure
REQ-035 The shared package holds the opcode constants, the shift_state encodings (LSH=10, RSH=01, HOLD=00) and the state encoding.
REQ-036 One sub-module, seq_down_counter (CNT_W wide; load, decrement and terminal-count output), is instantiated once.
REQ-037 No datapath registers live inside this block; it drives only the control ports of the register file and shift register.

Verification
REQ-038 Reset, then EXEC with ALU_LAT=1 -> lda=ldb=1 at cycle 1, ldo=1 at cycle 3, done at cycle 4 after accept.
REQ-039 LSH cnt=3, then RSH cnt=0 -> shift_state=10 for exactly 3 cycles and done at cycle 4; RSH gives done at cycle 1 with shift_state 00 throughout.
REQ-040 Opcode 111 -> done=1 and err=1 in the same cycle, with all enables 0 throughout.
REQ-041 instr_valid held high across a SHLD followed by LDA -> second accept occurs 1 cycle after done; instr_ready=0 in LOAD and DONE.
REQ-042 reset=0 during the SHIFT of LSH cnt=7 at shift cycle 4 -> shift_state=00 and instr_ready=1 the next cycle, with no done pulse.
REQ-043 Random opcode/cnt stream with assertions -> REQ-029 exclusivity holds and shift_state never equals 11.
